// File: rtl/video_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : video_timing_gen
// Brief    : Raster timing generator for NTSC/PAL at 15 kHz or 31 kHz; the
//            mode is latched only at frame wrap so frames are never torn.
// Revision : 1.0
// ============================================================================
module video_timing_gen #(
    parameter int HW            = 10,
    parameter int VW            = 10,
    parameter int FW            = 8,
    parameter int H_ACTIVE      = 529,
    parameter int H_SYNC_START  = 544,
    parameter int H_SYNC_END    = 590,
    parameter int H_TOTAL       = 638,
    parameter int NV_ACTIVE     = 240,
    parameter int NV_SYNC_START = 245,
    parameter int NV_SYNC_END   = 248,
    parameter int NV_TOTAL      = 262,
    parameter int PV_ACTIVE     = 300,
    parameter int PV_SYNC_START = 304,
    parameter int PV_SYNC_END   = 308,
    parameter int PV_TOTAL      = 312,
    parameter bit HS_POL        = 1'b1,
    parameter bit VS_POL        = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pal,
    input  logic          scandouble,
    output logic          ce_pix,
    output logic [HW-1:0] hcount,
    output logic [VW-1:0] vcount,
    output logic          hblank,
    output logic          vblank,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic          line_start,
    output logic          frame_start,
    output logic [FW-1:0] frame_cnt,
    output logic [1:0]    mode
);

    localparam logic [HW-1:0] c_H_ACTIVE = HW'(H_ACTIVE);
    localparam logic [HW-1:0] c_H_SS     = HW'(H_SYNC_START);
    localparam logic [HW-1:0] c_H_SE     = HW'(H_SYNC_END);
    localparam logic [HW-1:0] c_H_LAST   = HW'(H_TOTAL - 1);

    if (!(H_ACTIVE < H_SYNC_START && H_SYNC_START < H_SYNC_END &&
          H_SYNC_END <= H_TOTAL && H_TOTAL <= (1 << HW))) begin : g_bad_h
        $error("video_timing_gen: illegal horizontal timing parameters");
    end
    if (!(NV_ACTIVE < NV_SYNC_START && NV_SYNC_START < NV_SYNC_END &&
          NV_SYNC_END <= NV_TOTAL && 2 * NV_TOTAL <= (1 << VW))) begin : g_bad_nv
        $error("video_timing_gen: illegal NTSC vertical timing parameters");
    end
    if (!(PV_ACTIVE < PV_SYNC_START && PV_SYNC_START < PV_SYNC_END &&
          PV_SYNC_END <= PV_TOTAL && 2 * PV_TOTAL <= (1 << VW))) begin : g_bad_pv
        $error("video_timing_gen: illegal PAL vertical timing parameters");
    end

    // Pick the NTSC/PAL value and double it for 31 kHz operation.
    function automatic logic [VW-1:0] f_vsel(input logic p, input logic sd,
                                             input int ntsc_v, input int pal_v);
        logic [VW-1:0] v;
        v = p ? VW'(pal_v) : VW'(ntsc_v);
        return sd ? {v[VW-2:0], 1'b0} : v;
    endfunction

    logic          r_ce;
    logic          r_first;
    logic [HW-1:0] r_hcount;
    logic [VW-1:0] r_vcount;
    logic [FW-1:0] r_frame_cnt;
    logic [1:0]    r_mode;
    logic          r_hblank;
    logic          r_vblank;
    logic          r_hsync;
    logic          r_vsync;
    logic          r_de;
    logic          r_line_start;
    logic          r_frame_start;

    logic          w_ce_nxt;
    logic [VW-1:0] w_vt_last;
    logic [HW-1:0] w_h_nxt;
    logic [VW-1:0] w_v_nxt;
    logic [FW-1:0] w_fc_nxt;
    logic [1:0]    w_mode_nxt;
    logic [VW-1:0] w_va;
    logic [VW-1:0] w_vss;
    logic [VW-1:0] w_vse;
    logic          w_hs_act;
    logic          w_vs_act;

    assign w_ce_nxt  = r_mode[0] ? 1'b1 : ~r_ce;
    assign w_vt_last = f_vsel(r_mode[1], r_mode[0], NV_TOTAL, PV_TOTAL) - VW'(1);

    // The first pixel after reset presents position 0,0 instead of advancing.
    always_comb begin
        w_h_nxt    = r_hcount;
        w_v_nxt    = r_vcount;
        w_fc_nxt   = r_frame_cnt;
        w_mode_nxt = r_mode;
        if (r_first) begin
            w_h_nxt = '0;
            w_v_nxt = '0;
        end else if (r_hcount == c_H_LAST) begin
            w_h_nxt = '0;
            if (r_vcount == w_vt_last) begin
                w_v_nxt    = '0;
                w_fc_nxt   = r_frame_cnt + FW'(1);
                w_mode_nxt = {pal, scandouble};
            end else begin
                w_v_nxt = r_vcount + VW'(1);
            end
        end else begin
            w_h_nxt = r_hcount + HW'(1);
        end
    end

    // Output decode uses the mode that will be in force for the next pixel.
    assign w_va     = f_vsel(w_mode_nxt[1], w_mode_nxt[0], NV_ACTIVE, PV_ACTIVE);
    assign w_vss    = f_vsel(w_mode_nxt[1], w_mode_nxt[0], NV_SYNC_START, PV_SYNC_START);
    assign w_vse    = f_vsel(w_mode_nxt[1], w_mode_nxt[0], NV_SYNC_END, PV_SYNC_END);
    assign w_hs_act = (w_h_nxt >= c_H_SS) && (w_h_nxt < c_H_SE);
    assign w_vs_act = ((w_v_nxt > w_vss) || ((w_v_nxt == w_vss) && (w_h_nxt >= c_H_SS))) &&
                      ((w_v_nxt < w_vse) || ((w_v_nxt == w_vse) && (w_h_nxt < c_H_SS)));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ce          <= 1'b0;
            r_first       <= 1'b1;
            r_hcount      <= '0;
            r_vcount      <= '0;
            r_frame_cnt   <= '0;
            r_mode        <= {pal, scandouble};
            r_hblank      <= 1'b0;
            r_vblank      <= 1'b0;
            r_hsync       <= ~HS_POL;
            r_vsync       <= ~VS_POL;
            r_de          <= 1'b1;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_ce          <= w_ce_nxt;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            if (w_ce_nxt) begin
                r_first       <= 1'b0;
                r_hcount      <= w_h_nxt;
                r_vcount      <= w_v_nxt;
                r_frame_cnt   <= w_fc_nxt;
                r_mode        <= w_mode_nxt;
                r_hblank      <= (w_h_nxt >= c_H_ACTIVE);
                r_vblank      <= (w_v_nxt >= w_va);
                r_hsync       <= w_hs_act ? HS_POL : ~HS_POL;
                r_vsync       <= w_vs_act ? VS_POL : ~VS_POL;
                r_de          <= (w_h_nxt < c_H_ACTIVE) && (w_v_nxt < w_va);
                r_line_start  <= (w_h_nxt == '0);
                r_frame_start <= (w_h_nxt == '0) && (w_v_nxt == '0);
            end
        end
    end

    assign ce_pix      = r_ce;
    assign hcount      = r_hcount;
    assign vcount      = r_vcount;
    assign frame_cnt   = r_frame_cnt;
    assign mode        = r_mode;
    assign hblank      = r_hblank;
    assign vblank      = r_vblank;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign de          = r_de;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

endmodule
`default_nettype wire
